// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type and the baud divider calculation shared by rx and tx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  function automatic int baud_div(real clk_freq, real baudrate, int oversample);
    return int'(clk_freq / (baudrate * oversample));
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input plus received byte, strobes and busy flag of the receiver.
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done_tick;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;
  modport master (output rx, input rx_data, rx_done_tick, frame_err, parity_err, rx_busy);
  modport slave  (input rx, output rx_data, rx_done_tick, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_rx_baud_gen.sv
// baud_gen: free-running divider, one-cycle tick every DIV clocks.
module baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver; define UART_RX_PARITY_EN for 8E1 frames with even parity check.
module uart_rx
  import uart_pkg::*;
#(
  parameter real CLK_FREQ   = 100_000_000.0,
  parameter real BAUDRATE   = 115_200.0,
  parameter int  OVERSAMPLE = 16,
  parameter int  DATA_BITS  = 8
) (
  input logic      clk,
  input logic      reset_n,
  uart_rx_if.slave bus
);
  localparam int DIV = baud_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int NW  = $clog2(DATA_BITS + 1);
  rx_state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d, perr_q, perr_d;
  logic rx_m, rx_s, tick, last_s, half_s, par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  localparam rx_state_t AFTER_DATA = PARITY;
  assign par_bad = par_q ^ (^sh_q);
`else
  localparam rx_state_t AFTER_DATA = STOP;
  assign par_bad = 1'b0;
`endif
  baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .reset_n(reset_n), .tick(tick));
  assign last_s = s_q == SW'(OVERSAMPLE - 1);
  assign half_s = s_q == SW'(OVERSAMPLE / 2 - 1);
  assign bus.rx_data      = data_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.parity_err   = perr_q;
  assign bus.rx_busy      = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = rx_s ? IDLE : START;
        s_d     = '0;
      end
      START: if (tick) begin
        state_d = half_s ? (rx_s ? IDLE : DATA) : START;
        s_d     = half_s ? '0 : s_q + 1'b1;
        n_d     = '0;
      end
      DATA: if (tick) begin
        s_d = last_s ? '0 : s_q + 1'b1;
        if (last_s) begin
          sh_d    = {rx_s, sh_q[DATA_BITS-1:1]};
          n_d     = n_q + 1'b1;
          state_d = (n_q == NW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        s_d     = last_s ? '0 : s_q + 1'b1;
        par_d   = last_s ? rx_s : par_q;
        state_d = last_s ? STOP : PARITY;
      end
`endif
      STOP: if (tick) begin
        s_d = last_s ? '0 : s_q + 1'b1;
        if (last_s) begin
          state_d = rx_s ? IDLE : BREAK;
          done_d  = rx_s & ~par_bad;
          data_d  = (rx_s & ~par_bad) ? sh_q : data_q;
          ferr_d  = ~rx_s;
          perr_d  = par_bad;
        end
      end
      BREAK: state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rx_m    <= bus.rx;
      rx_s    <= rx_m;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
endmodule
